// File: rtl/relm_mul_iter.sv
// ---------------------------------------------------------------------------
// relm_mul_iter
//   Iterative shared multiplier behind the ReLM custom-instruction multiplier
//   port. Operands are converted to magnitudes at issue, WS multiplier bits are
//   consumed per RUN cycle, and the sign is applied once in FIX. Signed,
//   unsigned and mixed-sign operands are supported.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         synchronous active-high reset
//   start_in    request strobe, sampled only in IDLE
//   sign_a_in   treat mul_a_in as two's complement
//   sign_x_in   treat mul_x_in as two's complement
//   mul_a_in    multiplicand (WD bits)
//   mul_x_in    multiplier (WD bits)
//   mul_ax_out  registered 2*WD-bit product, held until the next done_out
//   busy_out    high while an operation is in flight (state != IDLE)
//   done_out    one-cycle pulse when mul_ax_out is updated
// ---------------------------------------------------------------------------
module relm_mul_iter #(
    parameter int WD = 32,
    parameter int WS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              sign_a_in,
    input  logic              sign_x_in,
    input  logic [WD-1:0]     mul_a_in,
    input  logic [WD-1:0]     mul_x_in,
    output logic [2*WD-1:0]   mul_ax_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int N  = WD / WS;
    // Keep the counter at least one bit wide so WS == WD still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WD-1:0]       r_amag;
    logic                r_neg;
    logic [2*WD-1:0]     r_p;
    logic [CW-1:0]       r_cnt;
    logic [2*WD-1:0]     r_mul_ax;
    logic                r_done;

    // Operand magnitudes at issue; the most negative value maps to 2^(WD-1),
    // which still fits in WD unsigned bits.
    logic                w_a_neg;
    logic                w_x_neg;
    logic [WD-1:0]       w_amag;
    logic [WD-1:0]       w_xmag;

    assign w_a_neg = sign_a_in & mul_a_in[WD-1];
    assign w_x_neg = sign_x_in & mul_x_in[WD-1];
    assign w_amag  = w_a_neg ? (WD'(0) - mul_a_in) : mul_a_in;
    assign w_xmag  = w_x_neg ? (WD'(0) - mul_x_in) : mul_x_in;

    // One radix-2^WS step: the low WS bits of P hold the next multiplier digit,
    // the partial product is added into the upper half, then P shifts right.
    // The sum needs WS extra bits before the shift; after it, 2*WD suffices.
    logic [WD+WS-1:0]    w_part;
    logic [2*WD+WS-1:0]  w_sum;
    logic [2*WD-1:0]     w_p_next;

    assign w_part   = {{WS{1'b0}}, r_amag} * {{WD{1'b0}}, r_p[WS-1:0]};
    assign w_sum    = {{WS{1'b0}}, r_p} + {w_part, {WD{1'b0}}};
    assign w_p_next = w_sum[2*WD+WS-1:WS];

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for w_state_next.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amag   <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_mul_ax <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_amag <= w_amag;
                        r_neg  <= w_a_neg ^ w_x_neg;
                        r_p    <= {{WD{1'b0}}, w_xmag};
                        r_cnt  <= CW'(N - 1);
                    end
                end
                S_RUN: begin
                    r_p <= w_p_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    // A zero magnitude negates to zero, so no -0 artefact.
                    r_mul_ax <= r_neg ? ((2*WD)'(0) - r_p) : r_p;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mul_ax_out = r_mul_ax;
    assign busy_out   = (r_state != S_IDLE);
    assign done_out   = r_done;

endmodule

// File: tb/tb_relm_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_relm_mul_iter
//   Self-checking bench for relm_mul_iter. Three instances (WS = 8, 4, 32)
//   share clock, reset and request inputs; results, latency, busy duration
//   and done pulse count are checked per instance against a reference model
//   that multiplies sign/zero-extended operands with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_relm_mul_iter;

    localparam int WD = 32;
    localparam int NI = 3;

    logic              clk;
    logic              rst;
    logic              start_in;
    logic              sign_a_in;
    logic              sign_x_in;
    logic [WD-1:0]     mul_a_in;
    logic [WD-1:0]     mul_x_in;
    logic [2*WD-1:0]   mul_ax [NI];
    logic [NI-1:0]     busy;
    logic [NI-1:0]     done;

    // Iterations per instance: WS=8 -> 4, WS=4 -> 8, WS=32 -> 1.
    int n_of [NI] = '{4, 8, 1};

    int checks = 0;
    int errors = 0;

    relm_mul_iter #(.WD(WD), .WS(8)) u_dut_ws8 (
        .clk(clk), .rst(rst), .start_in(start_in),
        .sign_a_in(sign_a_in), .sign_x_in(sign_x_in),
        .mul_a_in(mul_a_in), .mul_x_in(mul_x_in),
        .mul_ax_out(mul_ax[0]), .busy_out(busy[0]), .done_out(done[0])
    );

    relm_mul_iter #(.WD(WD), .WS(4)) u_dut_ws4 (
        .clk(clk), .rst(rst), .start_in(start_in),
        .sign_a_in(sign_a_in), .sign_x_in(sign_x_in),
        .mul_a_in(mul_a_in), .mul_x_in(mul_x_in),
        .mul_ax_out(mul_ax[1]), .busy_out(busy[1]), .done_out(done[1])
    );

    relm_mul_iter #(.WD(WD), .WS(32)) u_dut_ws32 (
        .clk(clk), .rst(rst), .start_in(start_in),
        .sign_a_in(sign_a_in), .sign_x_in(sign_x_in),
        .mul_a_in(mul_a_in), .mul_x_in(mul_x_in),
        .mul_ax_out(mul_ax[2]), .busy_out(busy[2]), .done_out(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the product modulo 2^(2*WD) of the operands interpreted as
    // signed or unsigned integers.
    function automatic logic [2*WD-1:0] ref_mul(input logic [WD-1:0] a, input logic [WD-1:0] x,
                                                input logic sa, input logic sx);
        logic signed [2*WD-1:0] ea;
        logic signed [2*WD-1:0] ex;
        ea = sa ? {{WD{a[WD-1]}}, a} : {{WD{1'b0}}, a};
        ex = sx ? {{WD{x[WD-1]}}, x} : {{WD{1'b0}}, x};
        return ea * ex;
    endfunction

    function automatic logic [WD-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation with all instances idle and watch all three until
    // they have finished; inputs are scrambled after issue.
    task automatic run_op(input string name, input logic [WD-1:0] a, input logic [WD-1:0] x,
                          input logic sa, input logic sx, input logic [2*WD-1:0] exp);
        int lat [NI];
        int ndone [NI];
        int nbusy [NI];
        logic [2*WD-1:0] res [NI];
        for (int i = 0; i < NI; i++) begin
            lat[i] = 0; ndone[i] = 0; nbusy[i] = 0; res[i] = '0;
        end
        mul_a_in = a; mul_x_in = x; sign_a_in = sa; sign_x_in = sx; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        mul_a_in = $urandom; mul_x_in = $urandom;
        sign_a_in = 1'($urandom); sign_x_in = 1'($urandom);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            for (int i = 0; i < NI; i++) begin
                if (busy[i]) nbusy[i]++;
                if (done[i]) begin
                    ndone[i]++;
                    if (ndone[i] == 1) begin
                        lat[i] = k;
                        res[i] = mul_ax[i];
                    end
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_res%0d", name, i), res[i], exp);
            check($sformatf("%s_lat%0d", name, i), lat[i], n_of[i] + 1);
            check($sformatf("%s_ndone%0d", name, i), ndone[i], 1);
            check($sformatf("%s_busy%0d", name, i), nbusy[i], n_of[i] + 1);
        end
    endtask

    task automatic drain(input int cycles);
        start_in = 1'b0;
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        logic [2*WD-1:0] res;
        logic [WD-1:0] ra;
        logic [WD-1:0] rx;
        logic rsa;
        logic rsx;

        rst = 1'b1; start_in = 1'b0; sign_a_in = 1'b0; sign_x_in = 1'b0;
        mul_a_in = '0; mul_x_in = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_mul%0d", i), mul_ax[i], 0);
            check($sformatf("rst_busy%0d", i), busy[i], 0);
            check($sformatf("rst_done%0d", i), done[i], 0);
        end

        // Directed corner cases.
        run_op("umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("smin",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
        run_op("sneg",   32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mixed",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
        run_op("zero",   32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0);

        // Back-to-back issue on the WS=8 instance, with a stray start in RUN.
        mul_a_in = 32'd7; mul_x_in = 32'd9; sign_a_in = 1'b0; sign_x_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done[0]) begin
                lat = k;
                break;
            end
        end
        check("b2b_first_lat", lat, 5);
        check("b2b_first_res", mul_ax[0], 63);
        mul_a_in = 32'd5; mul_x_in = 32'd6; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        lat = 0; ndone = 0; res = '0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 2) begin
                mul_a_in = 32'd99; mul_x_in = 32'd99; start_in = 1'b1;
            end
            tick();
            start_in = 1'b0;
            if (done[0]) begin
                ndone++;
                if (ndone == 1) begin
                    lat = k;
                    res = mul_ax[0];
                end
            end
        end
        check("b2b_second_lat", lat, 5);
        check("b2b_second_res", res, 30);
        check("b2b_ndone", ndone, 1);
        drain(20);

        // Reset in the third RUN cycle.
        mul_a_in = 32'hFFFF_FFFF; mul_x_in = 32'hFFFF_FFFF; sign_a_in = 1'b0; sign_x_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick();
        check("abort_busy_before", busy[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abort_mul%0d", i), mul_ax[i], 0);
            check($sformatf("abort_busy%0d", i), busy[i], 0);
            check($sformatf("abort_done%0d", i), done[i], 0);
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done != '0) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op("after_rst", 32'd2, 32'd3, 1'b0, 1'b0, 64'd6);

        // Random sweep against the reference model.
        for (int n = 0; n < 2000; n++) begin
            ra  = pick_operand();
            rx  = pick_operand();
            rsa = 1'($urandom);
            rsx = 1'($urandom);
            run_op("rand", ra, rx, rsa, rsx, ref_mul(ra, rx, rsa, rsx));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
